// File: rtl/ccastles_trackball.sv
// rtl/ccastles_trackball.sv - joystick/mouse to quadrature-style trackball counter emulator
// Optional mouse input path: CCASTLES_TRACKBALL_MOUSE_EN
module ccastles_trackball #(
  parameter int TICK_DIV  = 12000,
  parameter int DRAIN_DIV = 64,
  parameter int ACC_W     = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        joy,
  input  logic [1:0]        speed,
  input  logic              flip,
`ifdef CCASTLES_TRACKBALL_MOUSE_EN
  input  logic signed [8:0] mouse_dx,
  input  logic signed [8:0] mouse_dy,
  input  logic              mouse_tog,
`endif
  output logic [7:0]        trk_x,
  output logic [7:0]        trk_y,
  output logic              busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam int SW = ACC_W + 2;
  localparam int PMAX_I = 2 ** (ACC_W - 1) - 1;
  localparam logic signed [SW-1:0] PMAX = SW'(PMAX_I);
  localparam logic signed [SW-1:0] PMIN = -SW'(PMAX_I);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DRAIN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} state_t;

  logic [3:0]              r_joy_s1, r_joy_s2;
  logic [TW-1:0]           r_tick_cnt;
  logic                    w_tick;
  logic signed [SW-1:0]    w_mag;
  logic                    r_busy;

  state_t                  r_state     [2];
  state_t                  w_state_nxt [2];
  logic signed [ACC_W-1:0] r_pend      [2];
  logic signed [ACC_W-1:0] w_pend_nxt  [2];
  logic [DW-1:0]           r_dcnt      [2];
  logic [DW-1:0]           w_dcnt_nxt  [2];
  logic [7:0]              r_trk       [2];
  logic [7:0]              w_trk_nxt   [2];
  logic signed [SW-1:0]    w_joy_term  [2];
  logic signed [SW-1:0]    w_mouse_term[2];
  logic signed [SW-1:0]    w_drain     [2];
  logic signed [SW-1:0]    w_sum       [2];

  assign w_tick = (r_tick_cnt == TLAST);
  assign w_mag  = SW'(speed) + SW'(1);

`ifdef CCASTLES_TRACKBALL_MOUSE_EN
  logic [2:0] r_tog_s;
  logic       w_mouse_stb;

  assign w_mouse_stb = r_tog_s[1] ^ r_tog_s[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tog_s <= '0;
    else          r_tog_s <= {r_tog_s[1:0], mouse_tog};
  end

  // Deltas are held stable past the strobe, so they are folded straight into the accumulators.
  always_comb begin
    w_mouse_term[0] = '0;
    w_mouse_term[1] = '0;
    if (w_mouse_stb) begin
      w_mouse_term[0] = {{(SW-9){mouse_dx[8]}}, mouse_dx};
      w_mouse_term[1] = {{(SW-9){mouse_dy[8]}}, mouse_dy};
    end
  end
`else
  always_comb begin
    w_mouse_term[0] = '0;
    w_mouse_term[1] = '0;
  end
`endif

  always_comb begin
    w_joy_term[0] = '0;
    w_joy_term[1] = '0;
    if (w_tick) begin
      if (r_joy_s2[3] && !r_joy_s2[2]) w_joy_term[0] = w_mag;
      if (r_joy_s2[2] && !r_joy_s2[3]) w_joy_term[0] = -w_mag;
      if (r_joy_s2[1] && !r_joy_s2[0]) w_joy_term[1] = w_mag;
      if (r_joy_s2[0] && !r_joy_s2[1]) w_joy_term[1] = -w_mag;
    end
  end

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      w_drain[a]     = '0;
      w_trk_nxt[a]   = r_trk[a];
      w_dcnt_nxt[a]  = '0;
      w_state_nxt[a] = r_state[a];
      w_pend_nxt[a]  = r_pend[a];

      if (r_state[a] == S_STEP) begin
        if (!r_pend[a][ACC_W-1]) begin
          w_drain[a]   = '1;
          w_trk_nxt[a] = flip ? r_trk[a] - 8'd1 : r_trk[a] + 8'd1;
        end else begin
          w_drain[a]   = SW'(1);
          w_trk_nxt[a] = flip ? r_trk[a] + 8'd1 : r_trk[a] - 8'd1;
        end
      end

      w_sum[a] = SW'(r_pend[a]) + w_joy_term[a] + w_mouse_term[a] + w_drain[a];
      if (w_sum[a] > PMAX)      w_pend_nxt[a] = PMAX[ACC_W-1:0];
      else if (w_sum[a] < PMIN) w_pend_nxt[a] = PMIN[ACC_W-1:0];
      else                      w_pend_nxt[a] = w_sum[a][ACC_W-1:0];

      // FSM follows the post-update accumulator so the first step lands DRAIN_DIV+1 cycles out.
      case (r_state[a])
        S_IDLE: if (w_pend_nxt[a] != '0) w_state_nxt[a] = S_WAIT;
        S_WAIT: begin
          if (w_pend_nxt[a] == '0)   w_state_nxt[a] = S_IDLE;
          else if (r_dcnt[a] == DLAST) w_state_nxt[a] = S_STEP;
          else                        w_dcnt_nxt[a]  = r_dcnt[a] + DW'(1);
        end
        S_STEP: w_state_nxt[a] = (w_pend_nxt[a] != '0) ? S_WAIT : S_IDLE;
        default: w_state_nxt[a] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_joy_s1   <= '0;
      r_joy_s2   <= '0;
      r_tick_cnt <= '0;
      r_busy     <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        r_state[a] <= S_IDLE;
        r_pend[a]  <= '0;
        r_dcnt[a]  <= '0;
        r_trk[a]   <= '0;
      end
    end else begin
      r_joy_s1   <= joy;
      r_joy_s2   <= r_joy_s1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_busy     <= (w_pend_nxt[0] != '0) || (w_pend_nxt[1] != '0);
      for (int a = 0; a < 2; a++) begin
        r_state[a] <= w_state_nxt[a];
        r_pend[a]  <= w_pend_nxt[a];
        r_dcnt[a]  <= w_dcnt_nxt[a];
        r_trk[a]   <= w_trk_nxt[a];
      end
    end
  end

  assign trk_x = r_trk[0];
  assign trk_y = r_trk[1];
  assign busy  = r_busy;

endmodule

// File: tb/tb_ccastles_trackball.sv
// tb/tb_ccastles_trackball.sv - directed self-checking bench for ccastles_trackball
module tb_ccastles_trackball;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] joy;
  logic [1:0] speed;
  logic       flip;
  logic [7:0] trk_x, trk_y;
  logic       busy;
`ifdef CCASTLES_TRACKBALL_MOUSE_EN
  logic signed [8:0] mouse_dx, mouse_dy;
  logic              mouse_tog;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  logic seen_busy;

  always #5 clk = ~clk;

  ccastles_trackball #(.TICK_DIV(16), .DRAIN_DIV(4), .ACC_W(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .joy      (joy),
    .speed    (speed),
    .flip     (flip),
`ifdef CCASTLES_TRACKBALL_MOUSE_EN
    .mouse_dx (mouse_dx),
    .mouse_dy (mouse_dy),
    .mouse_tog(mouse_tog),
`endif
    .trk_x    (trk_x),
    .trk_y    (trk_y),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_busy_low(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    joy     = 4'b0000;
    speed   = 2'd0;
    flip    = 1'b0;
`ifdef CCASTLES_TRACKBALL_MOUSE_EN
    mouse_dx  = '0;
    mouse_dy  = '0;
    mouse_tog = 1'b0;
`endif
    cycles(3);
    check("rst_trk_x", {8'h0, trk_x}, 16'h0000);
    check("rst_trk_y", {8'h0, trk_y}, 16'h0000);
    check("rst_busy",  {15'h0, busy}, 16'h0000);

    // Right at speed 0, applied together with reset release
    reset_n = 1'b1;
    joy     = 4'b1000;
    lat     = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (trk_x != 8'h00) begin
        lat = n;
        break;
      end
    end
    check("first_step_in_window", {15'h0, (lat >= 20 && lat <= 25)}, 16'h0001);
    check("first_step_x", {8'h0, trk_x}, 16'h0001);
    check("first_step_y", {8'h0, trk_y}, 16'h0000);
    cycles(16);
    check("one_per_tick_x", {8'h0, trk_x}, 16'h0002);
    joy = 4'b0000;
    cycles(30);
    check("right_done_x", {8'h0, trk_x}, 16'h0002);
    check("right_done_busy", {15'h0, busy}, 16'h0000);

    // Left at speed 3 for exactly five ticks: 20 steps, wrapping through 0xFF
    speed = 2'd3;
    joy   = 4'b0100;
    cycles(80);
    joy = 4'b0000;
    cycles(4);
    check("left_busy_high", {15'h0, busy}, 16'h0001);
    wait_busy_low(300);
    check("left_busy_fall", {15'h0, busy}, 16'h0000);
    check("left_trk_x", {8'h0, trk_x}, 16'h00EE);
    check("left_trk_y", {8'h0, trk_y}, 16'h0000);

    // Cocktail flip, down at speed 1 for one tick
    flip  = 1'b1;
    speed = 2'd1;
    joy   = 4'b0010;
    cycles(16);
    joy = 4'b0000;
    cycles(4);
    check("flip_busy_high", {15'h0, busy}, 16'h0001);
    wait_busy_low(100);
    check("flip_busy_fall", {15'h0, busy}, 16'h0000);
    check("flip_trk_y", {8'h0, trk_y}, 16'h00FE);
    check("flip_trk_x", {8'h0, trk_x}, 16'h00EE);
    flip = 1'b0;

    // Opposing directions cancel on both axes
    seen_busy = 1'b0;
    joy = 4'b1100;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    joy = 4'b0011;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    joy = 4'b0000;
    check("cancel_no_busy", {15'h0, seen_busy}, 16'h0000);
    check("cancel_trk_x", {8'h0, trk_x}, 16'h00EE);
    check("cancel_trk_y", {8'h0, trk_y}, 16'h00FE);

    // Reset mid-drain discards pending motion
    speed = 2'd3;
    joy   = 4'b1000;
    cycles(160);
    check("pre_reset_busy", {15'h0, busy}, 16'h0001);
    check("pre_reset_moved", {15'h0, trk_x != 8'hEE}, 16'h0001);
    reset_n = 1'b0;
    #1;
    check("async_rst_x", {8'h0, trk_x}, 16'h0000);
    check("async_rst_y", {8'h0, trk_y}, 16'h0000);
    check("async_rst_busy", {15'h0, busy}, 16'h0000);
    joy = 4'b0000;
    cycles(2);
    reset_n = 1'b1;
    cycles(40);
    check("post_rst_x", {8'h0, trk_x}, 16'h0000);
    check("post_rst_busy", {15'h0, busy}, 16'h0000);

`ifdef CCASTLES_TRACKBALL_MOUSE_EN
    // X: 255+255 = 510 steps; Y: -256-256 saturates to -511 before its first step
    mouse_dx  = 9'sd255;
    mouse_dy  = -9'sd256;
    mouse_tog = ~mouse_tog;
    cycles(4);
    mouse_tog = ~mouse_tog;
    cycles(100);
    check("mouse_busy_high", {15'h0, busy}, 16'h0001);
    wait_busy_low(4000);
    check("mouse_busy_fall", {15'h0, busy}, 16'h0000);
    check("mouse_trk_x", {8'h0, trk_x}, 16'h00FE);
    check("mouse_sat_trk_y", {8'h0, trk_y}, 16'h0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
